iss_lockstep_sched: RTL and testbench
=====================================

// Module: iss_lockstep_sched
// PURPOSE
//  Cosim scheduler that runs the C instruction-set simulator (DPI step/reset/state routines) in lockstep with the RTL core.
//  - Buffers DUT retirement events in a FIFO.
//  - Drains one event per cycle: steps the ISS and compares PC and rd writeback.
//  - Reports the first divergence and keeps counters.
//  - Sits in the CPU conv_tests bench, between the core retire port and the ISS. Simulation-only; not synthesised.
// PARAMETERS
//  FIFO_DEPTH        8             retire buffer entries; power of 2, >=2
//  BOOT_PC           32'h0000_0000 PC loaded into the ISS at init
//  HALT_ON_MISMATCH  1             1: stop draining after first mismatch; 0: keep checking
//  TRACE_EN          0             1: call iss_enable_trace at init
// PORTS
//  clk             in   1   clock, all state on posedge
//  rst             in   1   asynchronous reset, active-high
//  enable          in   1   start lockstep; sampled in IDLE
//  retire_valid    in   1   core retired one instruction
//  retire_ready    out  1   FIFO can accept (= !full)
//  retire_pc       in   32  PC of retired instruction
//  retire_rd_we    in   1   instruction wrote rd
//  retire_rd_addr  in   5   destination register
//  retire_rd_data  in   32  value written
//  busy            out  1   state is INIT or CHECK, or FIFO non-empty
//  mismatch        out  1   sticky: first divergence seen
//  mismatch_code   out  2   0 none, 1 PC, 2 RD data, 3 overflow (push while full)
//  mismatch_pc     out  32  DUT PC of the first mismatching entry
//  checked_count   out  32  entries compared; saturates at 32'hFFFF_FFFF
// BEHAVIOUR
//  Reset (async, rst=1): FIFO empty, state IDLE. All outputs 0, except retire_ready=1. No DPI calls while rst=1.
//  States and transitions:
//   - IDLE->INIT when enable=1.
//   - INIT (1 cycle): iss_reset; iss_set_pc(BOOT_PC); if TRACE_EN, iss_enable_trace. Then ->CHECK.
//   - CHECK: pops one entry per cycle while FIFO is non-empty.
//   - CHECK->HALT on first mismatch when HALT_ON_MISMATCH=1.
//   - HALT: terminal until rst. FIFO still accepts pushes; no pops.
//  Push: retire_valid && retire_ready writes an entry at the posedge.
//   - retire_valid while full is dropped, and sets mismatch with code 3.
//   - No same-cycle bypass: the earliest pop is the cycle after the push.
//  Pop/check, all DPI calls in one posedge block, in this order:
//   1. p = iss_get_pc(); compare p to entry.pc. Mismatch -> code 1.
//   2. iss_step().
//   3. If rd_we && rd_addr!=0: compare iss_get_register(rd_addr) to rd_data. Mismatch -> code 2.
//   - rd_addr==0 writes are never compared.
//   - Ordering: code 1 checked first; a code-1 entry is not checked for code 2 (the ISS is still stepped).
//  Latency: push at edge N -> pop and check at edge N+1 -> mismatch/checked_count visible after edge N+1.
//  Mismatch fields: mismatch, mismatch_code and mismatch_pc latch on the first event only and are sticky until rst.
//   - checked_count increments on every pop, including the mismatching pop.
//  Simultaneous push and pop: allowed when not full. Count unchanged; pointers wrap mod FIFO_DEPTH.
//  enable deasserted after INIT: ignored, lockstep continues.
//  rst mid-CHECK: FIFO is flushed and no DPI call is issued that cycle. The ISS is re-initialised on the next INIT.
// STRUCTURE
//  cosim_pkg (shared):
//   - retire_entry_t struct {pc, rd_we, rd_addr, rd_data}
//   - mismatch_code_e enum {MM_NONE, MM_PC, MM_RD, MM_OVF}
//   - sched_state_e enum {S_IDLE, S_INIT, S_CHECK, S_HALT}
//  Imports iss_pkg for the DPI routines.
//  Sub-module retire_fifo: parameterised sync FIFO of retire_entry_t.
//   - Ports: push, pop, din, dout, full, empty.
//   - Depth counter with extra bit to tell full from empty.
//  Top holds the FSM, the comparison, the counters and the DPI calls.
// TESTING
//  1. Preload iss_set_instruction with addi x1,x0,5 @0.
//     - Push {pc 0, we 1, rd 1, data 5} after enable.
//     - Expect mismatch=0, checked_count=1, iss_get_pc()==4.
//  2. Same program, push rd_data=6.
//     - Expect mismatch=1, code=2, mismatch_pc=0; state HALT.
//     - Further pushes are accepted but checked_count stays 1.
//  3. Push pc=4 as the first entry (ISS at 0).
//     - Expect code=1 and mismatch_pc=4.
//     - Register compare is skipped for that entry.
//  4. Hold enable=0, push 8 entries.
//     - Expect retire_ready=0 after the 8th push.
//     - Push a 9th: expect code=3 and entry dropped.
//  5. Continuous push and pop over 20 nop retirements (pc 0,4,..,76), with writes to x0 carrying garbage data.
//     - Expect mismatch=0 and checked_count=20.
//     - FIFO never exceeds 1 entry; pointer wrap exercised.
//  6. Assert rst with 3 entries queued in CHECK.
//     - Expect busy=0, retire_ready=1, checked_count=0 on the next cycle.
//     - Re-enable reruns INIT.

Source files
------------

// File: rtl/cosim_pkg.sv
// Shared types for the lockstep cosim scheduler: retire payload, mismatch codes, FSM states.
package cosim_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned REG_AW  = 5;
    localparam int unsigned CODE_W  = 2;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic              rd_we;
        logic [REG_AW-1:0] rd_addr;
        logic [XLEN-1:0]   rd_data;
    } retire_entry_t;

    typedef enum logic [CODE_W-1:0] {
        MM_NONE = 2'd0,
        MM_PC   = 2'd1,
        MM_RD   = 2'd2,
        MM_OVF  = 2'd3
    } mismatch_code_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_INIT  = 2'd1,
        S_CHECK = 2'd2,
        S_HALT  = 2'd3
    } sched_state_e;

endpackage

// File: rtl/iss_pkg.sv
// Behavioural instruction-set simulator: state plus step/reset/query routines used by the scheduler.
package iss_pkg;

    localparam int unsigned IMEM_WORDS = 64;
    localparam int unsigned IMEM_AW    = 6;

    logic [31:0] iss_imem [IMEM_WORDS];
    logic [31:0] iss_pc;
    logic [31:0] iss_regs [32];
    logic        iss_trace;

    function automatic void iss_set_instruction(input logic [31:0] addr, input logic [31:0] insn);
        iss_imem[IMEM_AW'(addr >> 2)] = insn;
    endfunction

    function automatic void iss_reset();
        iss_pc    = 32'd0;
        iss_trace = 1'b0;
        for (int i = 0; i < 32; i++) begin
            iss_regs[i] = 32'd0;
        end
    endfunction

    function automatic void iss_set_pc(input logic [31:0] pc);
        iss_pc = pc;
    endfunction

    function automatic void iss_enable_trace();
        iss_trace = 1'b1;
    endfunction

    function automatic logic [31:0] iss_get_pc();
        return iss_pc;
    endfunction

    function automatic logic [31:0] iss_get_register(input logic [4:0] r);
        return iss_regs[r];
    endfunction

    // Executes ADDI; every other encoding retires as a nop.
    function automatic void iss_step();
        logic [31:0] insn;
        insn = iss_imem[IMEM_AW'(iss_pc >> 2)];
        if (insn[6:0] == 7'h13 && insn[14:12] == 3'b000 && insn[11:7] != 5'd0) begin
            iss_regs[insn[11:7]] = iss_regs[insn[19:15]] + {{20{insn[31]}}, insn[31:20]};
        end
        iss_pc = iss_pc + 32'd4;
    endfunction

endpackage

// File: rtl/retire_fifo.sv
// Synchronous FIFO of retire entries; occupancy counter carries one extra bit to separate full from empty.
module retire_fifo
    import cosim_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  retire_entry_t din_i,
    output retire_entry_t dout_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    retire_entry_t   mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            push_ok_c, pop_ok_c;

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign push_ok_c = push_i && !full_o;
    assign pop_ok_c  = pop_i && !empty_o;
    assign dout_o    = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok_c) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_ok_c, pop_ok_c})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; only the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (push_ok_c) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/iss_lockstep_sched.sv
// Lockstep scheduler: buffers core retirements, steps the ISS once per drained entry,
// and latches the first divergence between core and ISS.
module iss_lockstep_sched
    import cosim_pkg::*;
    import iss_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH       = 8,
    parameter logic [31:0] BOOT_PC          = 32'h0000_0000,
    parameter bit          HALT_ON_MISMATCH = 1'b1,
    parameter bit          TRACE_EN         = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              retire_valid_i,
    output logic              retire_ready_o,
    input  logic [XLEN-1:0]   retire_pc_i,
    input  logic              retire_rd_we_i,
    input  logic [REG_AW-1:0] retire_rd_addr_i,
    input  logic [XLEN-1:0]   retire_rd_data_i,
    output logic              busy_o,
    output logic              mismatch_o,
    output logic [CODE_W-1:0] mismatch_code_o,
    output logic [XLEN-1:0]   mismatch_pc_o,
    output logic [XLEN-1:0]   checked_count_o
);

    sched_state_e   state_q, state_d;
    retire_entry_t  fifo_din, fifo_dout;
    logic           fifo_full, fifo_empty;
    logic           push_c, pop_c, ovf_c, halt_c;
    logic           mismatch_q;
    mismatch_code_e code_q;
    logic [XLEN-1:0] mm_pc_q, checked_q;

    assign fifo_din = '{pc: retire_pc_i, rd_we: retire_rd_we_i,
                        rd_addr: retire_rd_addr_i, rd_data: retire_rd_data_i};

    // Draining stops as soon as a mismatch is latched, before the FSM reaches HALT.
    assign halt_c = HALT_ON_MISMATCH && mismatch_q;
    assign push_c = retire_valid_i && !fifo_full;
    assign ovf_c  = retire_valid_i && fifo_full;
    assign pop_c  = (state_q == S_CHECK) && !fifo_empty && !halt_c;

    retire_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push_c),
        .pop_i   (pop_c),
        .din_i   (fifo_din),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (enable_i) state_d = S_INIT;
            S_INIT:  state_d = S_CHECK;
            S_CHECK: if (halt_c) state_d = S_HALT;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    function automatic void iss_init();
        iss_reset();
        iss_set_pc(BOOT_PC);
        if (TRACE_EN) iss_enable_trace();
    endfunction

    // PC is compared before stepping; the register is read back after the step.
    function automatic mismatch_code_e iss_check(input retire_entry_t e);
        logic pc_bad;
        pc_bad = (iss_get_pc() != e.pc);
        iss_step();
        if (pc_bad) return MM_PC;
        if (e.rd_we && e.rd_addr != '0 && iss_get_register(e.rd_addr) != e.rd_data) return MM_RD;
        return MM_NONE;
    endfunction

    // All ISS interaction happens here so the call order within an edge is fixed.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mismatch_q <= 1'b0;
            code_q     <= MM_NONE;
            mm_pc_q    <= '0;
            checked_q  <= '0;
        end else begin
            if (state_q == S_INIT) iss_init();
            if (ovf_c && !mismatch_q) begin
                mismatch_q <= 1'b1;
                code_q     <= MM_OVF;
                mm_pc_q    <= retire_pc_i;
            end
            if (pop_c) begin
                if (checked_q != '1) checked_q <= checked_q + XLEN'(1);
                case (iss_check(fifo_dout))
                    MM_PC: if (!mismatch_q) begin
                        mismatch_q <= 1'b1;
                        code_q     <= MM_PC;
                        mm_pc_q    <= fifo_dout.pc;
                    end
                    MM_RD: if (!mismatch_q) begin
                        mismatch_q <= 1'b1;
                        code_q     <= MM_RD;
                        mm_pc_q    <= fifo_dout.pc;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign retire_ready_o  = !fifo_full;
    assign busy_o          = (state_q == S_INIT) || (state_q == S_CHECK) || !fifo_empty;
    assign mismatch_o      = mismatch_q;
    assign mismatch_code_o = code_q;
    assign mismatch_pc_o   = mm_pc_q;
    assign checked_count_o = checked_q;

endmodule

// File: tb/tb_iss_lockstep_sched.sv
// Directed bench for the lockstep scheduler with hand-computed expectations.
module tb_iss_lockstep_sched;
    import iss_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        retire_valid;
    logic        retire_ready;
    logic [31:0] retire_pc;
    logic        retire_rd_we;
    logic [4:0]  retire_rd_addr;
    logic [31:0] retire_rd_data;
    logic        busy;
    logic        mismatch;
    logic [1:0]  mismatch_code;
    logic [31:0] mismatch_pc;
    logic [31:0] checked_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    iss_lockstep_sched dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .enable_i         (enable),
        .retire_valid_i   (retire_valid),
        .retire_ready_o   (retire_ready),
        .retire_pc_i      (retire_pc),
        .retire_rd_we_i   (retire_rd_we),
        .retire_rd_addr_i (retire_rd_addr),
        .retire_rd_data_i (retire_rd_data),
        .busy_o           (busy),
        .mismatch_o       (mismatch),
        .mismatch_code_o  (mismatch_code),
        .mismatch_pc_o    (mismatch_pc),
        .checked_count_o  (checked_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic start();
        enable = 1'b1;
        tick();
        enable = 1'b0;
        tick();
    endtask

    task automatic push(input logic [31:0] pc, input logic we, input logic [4:0] rd,
                        input logic [31:0] data);
        retire_valid   = 1'b1;
        retire_pc      = pc;
        retire_rd_we   = we;
        retire_rd_addr = rd;
        retire_rd_data = data;
        tick();
        retire_valid   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; retire_valid = 1'b0;
        retire_pc = '0; retire_rd_we = 1'b0; retire_rd_addr = '0; retire_rd_data = '0;
        iss_set_instruction(32'h0, 32'h0050_0093);
        tick();
        tick();
        chk("rst_ready",   32'(retire_ready), 32'd1);
        chk("rst_busy",    32'(busy), 32'd0);
        chk("rst_mm",      32'(mismatch), 32'd0);
        chk("rst_code",    32'(mismatch_code), 32'd0);
        chk("rst_count",   checked_count, 32'd0);
        rst = 1'b0;

        // 1: matching addi x1,x0,5
        start();
        chk("t1_trace", 32'(iss_trace), 32'd0);
        push(32'h0, 1'b1, 5'd1, 32'd5);
        tick();
        chk("t1_mm",    32'(mismatch), 32'd0);
        chk("t1_count", checked_count, 32'd1);
        chk("t1_isspc", iss_get_pc(), 32'd4);
        chk("t1_x1",    iss_get_register(5'd1), 32'd5);
        chk("t1_busy",  32'(busy), 32'd1);

        // 2: rd data divergence, then halt
        do_reset();
        start();
        push(32'h0, 1'b1, 5'd1, 32'd6);
        tick();
        chk("t2_mm",    32'(mismatch), 32'd1);
        chk("t2_code",  32'(mismatch_code), 32'd2);
        chk("t2_mmpc",  mismatch_pc, 32'd0);
        chk("t2_count", checked_count, 32'd1);
        push(32'h4, 1'b0, 5'd0, 32'd0);
        push(32'h8, 1'b0, 5'd0, 32'd0);
        tick();
        tick();
        chk("t2_count_halt", checked_count, 32'd1);
        chk("t2_code_sticky", 32'(mismatch_code), 32'd2);
        chk("t2_busy",  32'(busy), 32'd1);

        // 3: PC divergence takes precedence over rd compare
        do_reset();
        start();
        push(32'h4, 1'b1, 5'd1, 32'd999);
        tick();
        chk("t3_code",  32'(mismatch_code), 32'd1);
        chk("t3_mmpc",  mismatch_pc, 32'd4);
        chk("t3_isspc", iss_get_pc(), 32'd4);

        // 4: fill while idle, then overflow
        do_reset();
        for (int i = 0; i < 8; i++) push(32'(i * 4), 1'b0, 5'd0, 32'd0);
        chk("t4_ready_full", 32'(retire_ready), 32'd0);
        chk("t4_mm_before",  32'(mismatch), 32'd0);
        push(32'h20, 1'b0, 5'd0, 32'd0);
        chk("t4_mm",    32'(mismatch), 32'd1);
        chk("t4_code",  32'(mismatch_code), 32'd3);
        chk("t4_mmpc",  mismatch_pc, 32'h20);
        chk("t4_ready", 32'(retire_ready), 32'd0);
        chk("t4_busy",  32'(busy), 32'd1);

        // 5: streaming nops with garbage x0 writes
        for (int i = 0; i < 20; i++) iss_set_instruction(32'(i * 4), 32'h0000_0013);
        do_reset();
        start();
        for (int i = 0; i < 20; i++) begin
            chk("t5_ready", 32'(retire_ready), 32'd1);
            push(32'(i * 4), 1'b1, 5'd0, 32'hDEAD_0000 + 32'(i));
        end
        tick();
        chk("t5_mm",    32'(mismatch), 32'd0);
        chk("t5_count", checked_count, 32'd20);
        chk("t5_isspc", iss_get_pc(), 32'd80);
        chk("t5_x0",    iss_get_register(5'd0), 32'd0);

        // 6: reset with entries queued in CHECK
        do_reset();
        for (int i = 0; i < 4; i++) push(32'(i * 4), 1'b0, 5'd0, 32'd0);
        start();
        tick();
        chk("t6_count_pre", checked_count, 32'd1);
        chk("t6_isspc_pre", iss_get_pc(), 32'd4);
        rst = 1'b1;
        #1;
        chk("t6_busy",  32'(busy), 32'd0);
        chk("t6_ready", 32'(retire_ready), 32'd1);
        chk("t6_count", checked_count, 32'd0);
        tick();
        rst = 1'b0;
        start();
        chk("t6_reinit_pc", iss_get_pc(), 32'd0);
        push(32'h0, 1'b0, 5'd0, 32'd0);
        tick();
        chk("t6_count_post", checked_count, 32'd1);
        chk("t6_mm_post",    32'(mismatch), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
